// File: rtl/pcie_scr_pkg.sv
// Shared constants and the 8-bit LFSR step for the PCIe Gen1/Gen2 TX scrambler.
// The polynomial is X^16+X^5+X^4+X^3+1 in Galois form, shifted LSB-first.
package pcie_scr_pkg;

   localparam logic [15:0] SCR_SEED = 16'hFFFF;
   localparam logic [15:0] SCR_POLY = 16'h0039;
   localparam logic [7:0]  K_COM    = 8'hBC;
   localparam logic [7:0]  K_SKP    = 8'h1C;

   // Returns {next_lfsr, key[7:0]}; key bit k is lfsr[15] before the k-th shift.
   function automatic logic [23:0] scr_advance8(input logic [15:0] lfsr);
      logic [15:0] s;
      logic [7:0]  key;
      s   = lfsr;
      key = '0;
      for (int k = 0; k < 8; k++) begin
         key[k] = s[15];
         s      = {s[14:0], 1'b0} ^ (s[15] ? SCR_POLY : 16'h0000);
      end
      return {s, key};
   endfunction

endpackage

// File: rtl/pcie_scr_symbol.sv
// One symbol slice of the scrambler: applies COM reseed, SKP hold, K/TS/disable
// bypass and hands the resulting LFSR state on to the next symbol in the lane.
module pcie_scr_symbol
   import pcie_scr_pkg::*;
(
   input  logic [15:0] lfsr_in,
   input  logic [7:0]  data,
   input  logic        k,
   input  logic        ts,
   input  logic        en,
   output logic [7:0]  data_out,
   output logic [15:0] lfsr_out
);

   logic [23:0] adv;

   assign adv = scr_advance8(lfsr_in);

   always_comb begin
      data_out = data;
      lfsr_out = adv[23:8];
      if (k && data == K_COM) begin
         lfsr_out = SCR_SEED;
      end else if (k && data == K_SKP) begin
         lfsr_out = lfsr_in;
      end else if (!k && !ts && en) begin
         data_out = data ^ adv[7:0];
      end
   end

endmodule

// File: rtl/pcie_multilane_scrambler.sv
// Multi-lane PCIe TX scrambler: per-lane LFSR chained across the beat's symbols,
// followed by a single registered valid/ready output stage.
module pcie_multilane_scrambler
   import pcie_scr_pkg::*;
#(
   parameter int LANES = 1,
   parameter int BYTES = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   input  logic [LANES*BYTES*8-1:0] data_i,
   input  logic [LANES*BYTES-1:0]   datak_i,
   input  logic [LANES*BYTES-1:0]   ts_i,
   input  logic                     scramble_en_i,
   input  logic                     lfsr_init_i,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   output logic [LANES*BYTES*8-1:0] data_o,
   output logic [LANES*BYTES-1:0]   datak_o
);

   logic [15:0]              lfsr_q [LANES];
   logic [15:0]              chain  [LANES][BYTES+1];
   logic [LANES*BYTES*8-1:0] scr_data;
   logic                     fire_in;
   logic                     fire_out;

   // A reseed cycle refuses input so no beat is scrambled with a half-updated state.
   assign in_ready_o = (~out_valid_o | out_ready_i) & ~lfsr_init_i;
   assign fire_in    = in_valid_i & in_ready_o;
   assign fire_out   = out_valid_o & out_ready_i;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign chain[l][0] = lfsr_q[l];
      for (genvar b = 0; b < BYTES; b++) begin : g_sym
         localparam int S = l * BYTES + b;
         pcie_scr_symbol u_sym (
            .lfsr_in  (chain[l][b]),
            .data     (data_i[S*8 +: 8]),
            .k        (datak_i[S]),
            .ts       (ts_i[S]),
            .en       (scramble_en_i),
            .data_out (scr_data[S*8 +: 8]),
            .lfsr_out (chain[l][b+1])
         );
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_valid_o <= 1'b0;
         data_o      <= '0;
         datak_o     <= '0;
         for (int l = 0; l < LANES; l++) lfsr_q[l] <= SCR_SEED;
      end else begin
         if (lfsr_init_i) begin
            for (int l = 0; l < LANES; l++) lfsr_q[l] <= SCR_SEED;
         end else if (fire_in) begin
            for (int l = 0; l < LANES; l++) lfsr_q[l] <= chain[l][BYTES];
         end
         if (fire_in) begin
            out_valid_o <= 1'b1;
            data_o      <= scr_data;
            datak_o     <= datak_i;
         end else if (fire_out) begin
            out_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pcie_multilane_scrambler.sv
// Self-checking bench for the two-lane scrambler: a reference LFSR model fills an
// expectation queue on every accepted beat, which is drained as output beats fire.
module tb_pcie_multilane_scrambler;

   localparam int LANES = 2;
   localparam int BYTES = 4;
   localparam int NS    = LANES * BYTES;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            in_valid_i;
   logic            in_ready_o;
   logic [NS*8-1:0] data_i;
   logic [NS-1:0]   datak_i;
   logic [NS-1:0]   ts_i;
   logic            scramble_en_i;
   logic            lfsr_init_i;
   logic            out_valid_o;
   logic            out_ready_i;
   logic [NS*8-1:0] data_o;
   logic [NS-1:0]   datak_o;

   int checks = 0;
   int errors = 0;
   bit rand_ready = 0;

   logic [15:0]          m_lfsr [LANES];
   logic [NS+NS*8-1:0]   exp_q [$];
   logic [NS+NS*8-1:0]   obs_q [$];

   pcie_multilane_scrambler #(.LANES(LANES), .BYTES(BYTES)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .in_valid_i    (in_valid_i),
      .in_ready_o    (in_ready_o),
      .data_i        (data_i),
      .datak_i       (datak_i),
      .ts_i          (ts_i),
      .scramble_en_i (scramble_en_i),
      .lfsr_init_i   (lfsr_init_i),
      .out_valid_o   (out_valid_o),
      .out_ready_i   (out_ready_i),
      .data_o        (data_o),
      .datak_o       (datak_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference: bit-serial Galois LFSR, one symbol at a time.
   function automatic logic [7:0] model_sym(int l, logic [7:0] d, logic k, logic t, logic en);
      logic [15:0] s;
      logic [7:0]  key;
      s = m_lfsr[l];
      if (k && d == 8'hBC) begin
         m_lfsr[l] = 16'hFFFF;
         return d;
      end
      if (k && d == 8'h1C) return d;
      for (int i = 0; i < 8; i++) begin
         key[i] = s[15];
         s = {s[14:0], 1'b0} ^ (s[15] ? 16'h0039 : 16'h0000);
      end
      m_lfsr[l] = s;
      return (k || t || !en) ? d : (d ^ key);
   endfunction

   // Scoreboard: every output fire pops one expectation.
   always @(negedge clk_i) begin
      logic [NS+NS*8-1:0] e;
      if (!rst_i && out_valid_o && out_ready_i) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_unexpected_beat got=%h", {datak_o, data_o});
         end else begin
            e = exp_q.pop_front();
            if ({datak_o, data_o} !== e) begin
               errors++;
               $display("FAIL scoreboard_beat got=%h exp=%h", {datak_o, data_o}, e);
            end
         end
         obs_q.push_back({datak_o, data_o});
      end
   end

   task automatic model_reseed();
      for (int l = 0; l < LANES; l++) m_lfsr[l] = 16'hFFFF;
   endtask

   task automatic send_beat(input logic [NS*8-1:0] d, input logic [NS-1:0] k,
                            input logic [NS-1:0] t, input logic en);
      logic [NS*8-1:0] ed;
      int n;
      n = 0;
      data_i = d; datak_i = k; ts_i = t; scramble_en_i = en; in_valid_i = 1'b1;
      do begin
         if (rand_ready) out_ready_i = 1'($urandom_range(0, 1));
         @(negedge clk_i);
         n++;
         if (!in_ready_o) begin
            @(posedge clk_i);
            #1;
         end
      end while (!in_ready_o && n < 200);
      if (!in_ready_o) begin
         errors++;
         $display("FAIL accept_timeout in_ready=%b required=1", in_ready_o);
      end else begin
         for (int l = 0; l < LANES; l++)
            for (int b = 0; b < BYTES; b++) begin
               int s;
               s = l * BYTES + b;
               ed[s*8 +: 8] = model_sym(l, d[s*8 +: 8], k[s], t[s], en);
            end
         exp_q.push_back({k, ed});
      end
      @(posedge clk_i);
      #1 in_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      out_ready_i = 1'b1;
      while ((exp_q.size() != 0 || out_valid_o) && n < 100) begin
         @(posedge clk_i);
         #1 n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      checks += 4;
      if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
      if (data_o !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", data_o); end
      if (datak_o !== '0) begin errors++; $display("FAIL reset_datak got=%h exp=0", datak_o); end
      if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); end
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_com_sequence();
      logic [NS+NS*8-1:0] o;
      obs_q.delete();
      send_beat(64'h00000000_000000BC, 8'b0000_0001, '0, 1'b1);
      send_beat('0, '0, '0, 1'b1);
      drain();
      checks++;
      if (obs_q.size() != 2) begin
         errors++; $display("FAIL com_count got=%0d exp=2", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         checks += 2;
         if (o[31:0] !== 32'hC017FFBC) begin errors++; $display("FAIL com_beat0 got=%h exp=C017FFBC", o[31:0]); end
         if (o[67:64] !== 4'b0001) begin errors++; $display("FAIL com_datak got=%b exp=0001", o[67:64]); end
         o = obs_q.pop_front();
         checks++;
         if (o[31:0] !== 32'h02E7B214) begin errors++; $display("FAIL com_beat1 got=%h exp=02E7B214", o[31:0]); end
      end
   endtask

   task automatic test_skp();
      logic [NS+NS*8-1:0] o;
      obs_q.delete();
      send_beat(64'h00000000_001C00BC, 8'b0000_0101, '0, 1'b1);
      drain();
      checks++;
      if (obs_q.size() != 1) begin
         errors++; $display("FAIL skp_count got=%0d exp=1", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         checks += 2;
         if (o[31:0] !== 32'h171CFFBC) begin errors++; $display("FAIL skp_beat got=%h exp=171CFFBC", o[31:0]); end
         if (o[67:64] !== 4'b0101) begin errors++; $display("FAIL skp_datak got=%b exp=0101", o[67:64]); end
      end
   endtask

   task automatic test_bypass();
      logic [NS+NS*8-1:0] o;
      for (int mode = 0; mode < 2; mode++) begin
         obs_q.delete();
         if (mode == 0) send_beat(64'h00000000_000000BC, 8'b0000_0001, 8'b0000_1110, 1'b1);
         else           send_beat(64'h00000000_000000BC, 8'b0000_0001, '0, 1'b0);
         send_beat('0, '0, '0, 1'b1);
         drain();
         checks++;
         if (obs_q.size() != 2) begin
            errors++; $display("FAIL bypass_count mode=%0d got=%0d exp=2", mode, obs_q.size());
         end else begin
            o = obs_q.pop_front();
            checks++;
            if (o[31:0] !== 32'h000000BC) begin errors++; $display("FAIL bypass_beat0 mode=%0d got=%h exp=000000BC", mode, o[31:0]); end
            o = obs_q.pop_front();
            checks++;
            if (o[31:0] !== 32'h02E7B214) begin errors++; $display("FAIL bypass_beat1 mode=%0d got=%h exp=02E7B214", mode, o[31:0]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [NS*8-1:0]    held;
      logic [NS+NS*8-1:0] o;
      obs_q.delete();
      out_ready_i = 1'b0;
      send_beat(64'h00000000_332211BC, 8'b0000_0001, '0, 1'b1);
      data_i = '0; datak_i = '0; ts_i = '0; scramble_en_i = 1'b1; in_valid_i = 1'b1;
      @(negedge clk_i);
      held = data_o;
      for (int c = 0; c < 5; c++) begin
         checks += 3;
         if (in_ready_o !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", c, in_ready_o); end
         if (out_valid_o !== 1'b1) begin errors++; $display("FAIL stall_out_valid cyc=%0d got=%b exp=1", c, out_valid_o); end
         if (data_o[31:0] !== 32'hF335EEBC || data_o !== held) begin
            errors++; $display("FAIL stall_data cyc=%0d got=%h exp=%h", c, data_o, held);
         end
         @(negedge clk_i);
      end
      @(posedge clk_i);
      #1 out_ready_i = 1'b1;
      send_beat('0, '0, '0, 1'b1);
      send_beat('0, '0, '0, 1'b1);
      drain();
      checks++;
      if (obs_q.size() != 3) begin
         errors++; $display("FAIL b2b_count got=%0d exp=3", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         checks++;
         if (o[31:0] !== 32'hF335EEBC) begin errors++; $display("FAIL b2b_beat0 got=%h exp=F335EEBC", o[31:0]); end
         o = obs_q.pop_front();
         checks++;
         if (o[31:0] !== 32'h02E7B214) begin errors++; $display("FAIL b2b_beat1 got=%h exp=02E7B214", o[31:0]); end
      end
   endtask

   task automatic test_lfsr_init();
      logic [NS+NS*8-1:0] o;
      send_beat('0, '0, '0, 1'b1);
      drain();
      lfsr_init_i = 1'b1; in_valid_i = 1'b1; data_i = '0; datak_i = '0; ts_i = '0;
      @(negedge clk_i);
      checks++;
      if (in_ready_o !== 1'b0) begin errors++; $display("FAIL init_in_ready got=%b exp=0", in_ready_o); end
      @(posedge clk_i);
      #1 lfsr_init_i = 1'b0; in_valid_i = 1'b0;
      model_reseed();
      obs_q.delete();
      send_beat('0, '0, '0, 1'b1);
      drain();
      checks++;
      if (obs_q.size() != 1) begin
         errors++; $display("FAIL init_count got=%0d exp=1", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         checks++;
         if (o[31:0] !== 32'h14C017FF) begin errors++; $display("FAIL init_beat got=%h exp=14C017FF", o[31:0]); end
      end
   endtask

   task automatic test_reset_midstream();
      logic [NS+NS*8-1:0] o;
      send_beat('0, '0, '0, 1'b1);
      drain();
      out_ready_i = 1'b0;
      send_beat('0, '0, '0, 1'b1);
      @(negedge clk_i);
      rst_i = 1'b1;
      #1;
      checks++;
      if (out_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid_o); end
      exp_q.delete();
      obs_q.delete();
      model_reseed();
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      out_ready_i = 1'b1;
      send_beat('0, '0, '0, 1'b1);
      drain();
      checks++;
      if (obs_q.size() != 1) begin
         errors++; $display("FAIL midrst_count got=%0d exp=1", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         checks++;
         if (o[31:0] !== 32'h14C017FF) begin errors++; $display("FAIL midrst_beat got=%h exp=14C017FF", o[31:0]); end
      end
   endtask

   task automatic test_lanes();
      logic [NS+NS*8-1:0] o;
      obs_q.delete();
      send_beat(64'h00000000_000000BC, 8'b0000_0001, '0, 1'b1);
      drain();
      checks++;
      if (obs_q.size() != 1) begin
         errors++; $display("FAIL lanes_count got=%0d exp=1", obs_q.size());
      end else begin
         o = obs_q.pop_front();
         checks += 2;
         if (o[31:0] !== 32'hC017FFBC) begin errors++; $display("FAIL lanes_lane0 got=%h exp=C017FFBC", o[31:0]); end
         if (o[63:32] === o[31:0]) begin errors++; $display("FAIL lanes_differ lane1=%h lane0=%h", o[63:32], o[31:0]); end
      end
   endtask

   task automatic test_random();
      logic [NS*8-1:0] d;
      logic [NS-1:0]   k;
      logic [NS-1:0]   t;
      rand_ready = 1;
      for (int i = 0; i < 40; i++) begin
         for (int s = 0; s < NS; s++) begin
            int r;
            r = int'($urandom_range(0, 9));
            d[s*8 +: 8] = 8'($urandom);
            k[s] = (r <= 2);
            if (r == 0) d[s*8 +: 8] = 8'hBC;
            if (r == 1) d[s*8 +: 8] = 8'h1C;
            t[s] = ($urandom_range(0, 7) == 0);
         end
         send_beat(d, k, t, ($urandom_range(0, 5) != 0));
      end
      rand_ready = 0;
      drain();
   endtask

   initial begin
      rst_i = 1'b1; in_valid_i = 1'b0; data_i = '0; datak_i = '0; ts_i = '0;
      scramble_en_i = 1'b1; lfsr_init_i = 1'b0; out_ready_i = 1'b1;
      model_reseed();
      test_reset();
      test_com_sequence();
      test_skp();
      test_bypass();
      test_back_to_back();
      test_lfsr_init();
      test_reset_midstream();
      test_lanes();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
